// File: rtl/seq_restoring_divider.sv
// Unsigned sequential restoring divider: one quotient bit per clock, start/ready/done handshake.
// Divide-by-zero short-circuits to DONE with an all-ones quotient and the dividend as remainder.
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] dividend_sh;
    logic [WIDTH-1:0] divisor_reg;
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] quo_work;

    logic [WIDTH:0]   trial;
    logic             trial_ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             last_step;

    // The compare is done at full WIDTH+1 width; when it succeeds the true difference
    // is below the divisor, so a WIDTH-bit subtraction yields it exactly.
    always_comb begin
        trial     = {part_rem, dividend_sh[WIDTH-1]};
        trial_ge  = (trial >= {1'b0, divisor_reg});
        rem_next  = trial_ge ? (trial[WIDTH-1:0] - divisor_reg) : trial[WIDTH-1:0];
        quo_next  = {quo_work[WIDTH-2:0], trial_ge};
        last_step = (count == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start_in) begin
                    state_next = (divisor_in == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Visible results change only on the accepting edge (divide-by-zero) or the final RUN edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            dividend_sh <= '0;
            divisor_reg <= '0;
            part_rem    <= '0;
            quo_work    <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_in) begin
                        if (divisor_in == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend_in;
                            div_by_zero <= 1'b1;
                        end else begin
                            dividend_sh <= dividend_in;
                            divisor_reg <= divisor_in;
                            part_rem    <= '0;
                            quo_work    <= '0;
                            count       <= '0;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    dividend_sh <= dividend_sh << 1;
                    part_rem    <= rem_next;
                    quo_work    <= quo_next;
                    count       <= count + CNT_W'(1);
                    if (last_step) begin
                        quotient  <= quo_next;
                        remainder <= rem_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
